// File: rtl/dvbs2_pkt_bit_serializer.sv
// Byte-to-bit serializer feeding the DVB-S2 transmitter pktIn bus, paced by nextFrame.
// Optional SYNC_CHECK_EN macro adds sync-byte checking with sync_err/sync_err_cnt.
module dvbs2_pkt_bit_serializer #(
  parameter int          DFL_BITS  = 42960,
  parameter int          UPL_BITS  = 1504,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        run,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        nextFrame,
  output logic [5:0]  pktOut,
  output logic        underflow,
  output logic [15:0] frame_cnt
`ifdef SYNC_CHECK_EN
  ,
  output logic        sync_err,
  output logic [15:0] sync_err_cnt
`endif
);

  localparam int FW = (DFL_BITS > 1) ? $clog2(DFL_BITS) : 1;
  localparam int PW = (UPL_BITS > 1) ? $clog2(UPL_BITS) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(DFL_BITS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(UPL_BITS - 1);

  typedef enum logic {WAIT_FRAME, SEND} state_t;

  state_t          state;
  state_t          state_nx;
  logic [7:0]      sh;
  logic [3:0]      bits_left;
  logic [FW-1:0]   frame_bit;
  logic [PW-1:0]   pkt_bit;
  logic [PW-1:0]   pkt_nx;
  logic            emitting;
  logic            accept;
  logic            f_end;
  logic            p_end;

  assign f_end  = (frame_bit == F_LAST);
  assign p_end  = (pkt_bit == P_LAST);
  assign accept = s_tvalid && s_tready;
  // packet position the next loaded byte's MSB will occupy
  assign pkt_nx = !emitting ? pkt_bit :
                  p_end     ? '0      : pkt_bit + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    emitting  = 1'b0;
    s_tready  = 1'b0;
    underflow = 1'b0;
    unique case (state)
      WAIT_FRAME: begin
        if (clk_enable && run && nextFrame) state_nx = SEND;
      end
      SEND: begin
        emitting  = clk_enable && (bits_left != 4'd0);
        s_tready  = clk_enable &&
                    ((bits_left == 4'd0) ||
                     ((bits_left == 4'd1) && emitting));
        underflow = clk_enable && (bits_left == 4'd0) && !s_tvalid;
        if (emitting && f_end) state_nx = WAIT_FRAME;
      end
      default: state_nx = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pktOut    <= '0;
      sh        <= '0;
      bits_left <= '0;
      frame_bit <= '0;
      pkt_bit   <= '0;
      frame_cnt <= '0;
    end else begin
      pktOut  <= '0;
      pkt_bit <= pkt_nx;
      if (emitting) begin
        pktOut    <= {sh[7], pkt_bit == '0, p_end, 1'b1,
                      frame_bit == '0, f_end};
        frame_bit <= f_end ? '0 : frame_bit + FW'(1);
        if (f_end) frame_cnt <= frame_cnt + 16'd1;
      end
      if (accept) begin
        sh        <= s_tdata;
        bits_left <= 4'd8;
      end else if (emitting) begin
        sh        <= {sh[6:0], 1'b0};
        bits_left <= bits_left - 4'd1;
      end
    end
  end

`ifdef SYNC_CHECK_EN
  assign sync_err = accept && (pkt_nx == '0) && (s_tdata != SYNC_BYTE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_err_cnt <= '0;
    else if (sync_err && (sync_err_cnt != 16'hFFFF))
      sync_err_cnt <= sync_err_cnt + 16'd1;
  end
`else
  logic unused_sync;
  assign unused_sync = ^SYNC_BYTE;
`endif

endmodule

// File: tb/tb_dvbs2_pkt_bit_serializer.sv
// Directed bench for dvbs2_pkt_bit_serializer with DFL=24, UPL=16.
// Bit stream checked against the accepted bytes; boundaries against hand values.
module tb_dvbs2_pkt_bit_serializer;

  localparam int DFL = 24;
  localparam int UPL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        run;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        nextFrame;
  logic [5:0]  pktOut;
  logic        underflow;
  logic [15:0] frame_cnt;
`ifdef SYNC_CHECK_EN
  logic        sync_err;
  logic [15:0] sync_err_cnt;
`endif

  dvbs2_pkt_bit_serializer #(
    .DFL_BITS (DFL),
    .UPL_BITS (UPL),
    .SYNC_BYTE(8'h47)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .run       (run),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .nextFrame (nextFrame),
    .pktOut    (pktOut),
    .underflow (underflow),
    .frame_cnt (frame_cnt)
`ifdef SYNC_CHECK_EN
    ,
    .sync_err    (sync_err),
    .sync_err_cnt(sync_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int idx = 0;
  int base = 0;
  int bad_rel = -1;
  int pb = 0;
  int fb = 0;
  int exp_frames = 0;
  int uf_seen = 0;
  int se_seen = 0;
  bit q[$];
  logic [4:0] log_q[$];
  logic [5:0] last_pkt;
  logic last_ready;
  bit last_acc;
  logic [7:0] odd_tab[4] = '{8'hA5, 8'h3C, 8'h96, 8'hE1};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    int r = i - base;
    if (r == bad_rel) return 8'h46;
    if (r % 2 == 0) return 8'h47;
    return odd_tab[(r / 2) % 4];
  endfunction

  task automatic tick();
    bit e;
    @(negedge clk);
    last_pkt = pktOut;
    last_ready = s_tready;
    if (underflow) uf_seen++;
`ifdef SYNC_CHECK_EN
    if (sync_err) se_seen++;
`endif
    if (pktOut[2]) begin
      if (q.size() == 0) chk("bitq", 0, 1);
      else begin
        e = q.pop_front();
        chk("bit", pktOut[5], e);
        chk("flags", {pktOut[4], pktOut[3], pktOut[1], pktOut[0]},
            {pb == 0, pb == UPL - 1, fb == 0, fb == DFL - 1});
        log_q.push_back({pktOut[5], pktOut[4], pktOut[3],
                         pktOut[1], pktOut[0]});
        if (fb == DFL - 1) exp_frames++;
        pb = (pb + 1) % UPL;
        fb = (fb + 1) % DFL;
        chk("frame_cnt", frame_cnt, exp_frames);
      end
    end else begin
      chk("gap", pktOut, 0);
    end
    last_acc = s_tvalid && s_tready;
    if (last_acc)
      for (int b = 7; b >= 0; b--) q.push_back(s_tdata[b]);
    @(posedge clk);
    #1;
    if (last_acc) begin
      idx++;
      s_tdata = byte_at(idx);
    end
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin
      tick();
      k++;
    end while (!last_pkt[1] && k < 100);
    chk("fs_seen", last_pkt[1], 1);
  endtask

  task automatic model_clear();
    q.delete();
    pb = 0;
    fb = 0;
    exp_frames = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    int n0;
    int g;
    int uf0;
    reset = 1'b1;
    clk_enable = 1'b1;
    run = 1'b1;
    nextFrame = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = byte_at(0);
    repeat (2) @(negedge clk);
    chk("rst_pkt", pktOut, 0);
    chk("rst_ready", s_tready, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_fcnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // frame 1, then hold off frame 2
    tick();
    nextFrame = 1'b0;
    k = 0;
    while (log_q.size() < DFL && k < 80) begin
      tick();
      k++;
    end
    chk("f1_len", log_q.size(), DFL);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_ready", last_ready, 0);
    end
    chk("hold_len", log_q.size(), DFL);
    chk("b0", log_q[0], 5'b01010);
    chk("b15", log_q[15], 5'b10100);
    chk("b23", log_q[23], 5'b10001);

    nextFrame = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_pkt[2] && k < 10);
    chk("start_lat", k - 1, 2);
    chk("f2_fs", last_pkt[1], 1);
    k = 0;
    while (log_q.size() < 40 && k < 80) begin
      tick();
      k++;
    end
    chk("b24", log_q[24], 5'b00010);
    chk("b32", log_q[32], 5'b01000);

    // starvation: valid low from the last-bit cycle of a byte for 5 cycles
    wait_fs();
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_acc && k < 20);
    repeat (7) tick();
    s_tvalid = 1'b0;
    uf0 = uf_seen;
    g = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!last_pkt[2]) g++;
      if (i == 4) s_tvalid = 1'b1;
    end
    chk("uf_pulses", uf_seen - uf0, 4);
    chk("uf_gap", g, 5);

    // clock-enable toggling
    wait_fs();
    repeat (2) tick();
    n0 = log_q.size();
    clk_enable = 1'b0;
    tick();
    chk("ce_v1", last_pkt[2], 1);
    chk("ce_rdy", last_ready, 0);
    clk_enable = 1'b1;
    tick();
    chk("ce_g1", last_pkt, 0);
    clk_enable = 1'b0;
    tick();
    chk("ce_v2", last_pkt[2], 1);
    clk_enable = 1'b1;
    tick();
    chk("ce_g2", last_pkt, 0);
    chk("ce_bits", log_q.size() - n0, 2);

    // reset in mid-frame
    wait_fs();
    k = 0;
    while (fb != 10 && k < 40) begin
      tick();
      k++;
    end
    chk("at_bit10", fb, 10);
    reset = 1'b1;
    #1;
    chk("mr_pkt", pktOut, 0);
    chk("mr_ready", s_tready, 0);
    chk("mr_uf", underflow, 0);
    chk("mr_fcnt", frame_cnt, 0);
    model_clear();
    tick();
    reset = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!last_pkt[2] && k < 20);
    chk("mr_ps", last_pkt[4], 1);
    chk("mr_fs", last_pkt[1], 1);
    chk("mr_fcnt2", frame_cnt, 0);
    repeat (30) tick();

`ifdef SYNC_CHECK_EN
    reset = 1'b1;
    model_clear();
    base = idx;
    bad_rel = 2;
    s_tdata = byte_at(idx);
    tick();
    chk("se_rst", sync_err_cnt, 0);
    reset = 1'b0;
    se_seen = 0;
    repeat (40) tick();
    chk("se_pulses", se_seen, 1);
    chk("se_cnt", sync_err_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
